// File: rtl/lif_neuron_array_core_if.sv
// Bus bundle for lif_neuron_array_core: run controls, serial
// config stream and neuron status outputs.
interface lif_neuron_array_core_if #(
  parameter int NUM_CH = 2,
  parameter int IN_W   = 3,
  parameter int V_W    = 7
);
  logic                   enable;
  logic [NUM_CH*IN_W-1:0] chan_in;
  logic                   load_mode;
  logic                   serial_data;
  logic                   spike_out;
  logic [V_W-1:0]         v_mem_out;
  logic                   params_ready;
  logic                   cfg_err;
  logic [7:0]             spike_count;

  modport master (
    output enable, chan_in,
    output load_mode, serial_data,
    input  spike_out, v_mem_out,
    input  params_ready, cfg_err,
    input  spike_count
  );

  modport slave (
    input  enable, chan_in,
    input  load_mode, serial_data,
    output spike_out, v_mem_out,
    output params_ready, cfg_err,
    output spike_count
  );
endinterface

// File: rtl/lif_neuron_array_core.sv
// Parametrised LIF neuron core with serial config and refractory period.
// Optional spike counter enabled by defining LIF_SPIKE_COUNT_EN.
module lif_neuron_array_core #(
  parameter int NUM_CH = 2,
  parameter int IN_W   = 3,
  parameter int W_W    = 3,
  parameter int V_W    = 7,
  parameter int LEAK_W = 3,
  parameter int REF_W  = 3
) (
  input logic clk,
  input logic rst_n,
  lif_neuron_array_core_if.slave io
);
  localparam int CFG_BITS = V_W + LEAK_W + REF_W + NUM_CH*W_W;
  localparam int CNT_W = $clog2(CFG_BITS + 2);
  localparam int S_W = IN_W + W_W + $clog2(NUM_CH) + 1;
  localparam int E_W = ((S_W > V_W) ? S_W : V_W) + 2;
  localparam logic [E_W-1:0] V_MAX =
    {{(E_W-V_W){1'b0}}, {V_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE, LOAD, RUN, REFRAC
  } state_t;

  state_t                   state;
  logic [CFG_BITS-1:0]      shift_reg;
  logic [CNT_W-1:0]         bit_cnt;
  logic [V_W-1:0]           thresh;
  logic [LEAK_W-1:0]        leak;
  logic [REF_W-1:0]         refr;
  logic [NUM_CH-1:0][W_W-1:0] w;
  logic [REF_W-1:0]         ref_cnt;
  logic [V_W-1:0]           v;
  logic                     spike_q;
  logic                     ready_q;
  logic                     err_q;

  logic [E_W-1:0] sum;
  logic [E_W-1:0] acc;
  logic [E_W-1:0] diff;
  logic [V_W-1:0] v_next;
  logic           fire;
  logic           active;
  logic           commit;
  logic           spike_ev;

  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = sum + (E_W'(w[k]) *
        E_W'(io.chan_in[k*IN_W +: IN_W]));
    end
    acc  = E_W'(v) + sum;
    diff = acc - E_W'(leak);
    if (acc < E_W'(leak)) begin
      v_next = '0;
    end else if (diff > V_MAX) begin
      v_next = V_MAX[V_W-1:0];
    end else begin
      v_next = diff[V_W-1:0];
    end
    fire = (thresh != '0) && (v_next >= thresh);
  end

  assign active   = io.enable && !io.load_mode;
  assign commit   = active && (state == LOAD) &&
                    (bit_cnt == CNT_W'(CFG_BITS));
  assign spike_ev = active && (state == RUN) && fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      thresh    <= '0;
      leak      <= '0;
      refr      <= '0;
      w         <= '0;
      ref_cnt   <= '0;
      v         <= '0;
      spike_q   <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else if (!io.enable) begin
      spike_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      spike_q <= 1'b0;
      err_q   <= 1'b0;
      if (io.load_mode) begin
        // the entry cycle already carries the first bit
        if (state != LOAD) begin
          bit_cnt <= CNT_W'(1);
        end else if (bit_cnt != CNT_W'(CFG_BITS + 1)) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
        shift_reg <= {shift_reg[CFG_BITS-2:0], io.serial_data};
        state     <= LOAD;
        v         <= '0;
        ref_cnt   <= '0;
        ready_q   <= 1'b0;
      end else begin
        unique case (state)
          LOAD: begin
            if (commit) begin
              thresh  <= shift_reg[CFG_BITS-1 -: V_W];
              leak    <= shift_reg[REF_W+NUM_CH*W_W +: LEAK_W];
              refr    <= shift_reg[NUM_CH*W_W +: REF_W];
              w       <= shift_reg[NUM_CH*W_W-1:0];
              ready_q <= 1'b1;
              state   <= RUN;
            end else begin
              thresh <= '0;
              leak   <= '0;
              refr   <= '0;
              w      <= '0;
              err_q  <= 1'b1;
              state  <= IDLE;
            end
          end
          IDLE: v <= '0;
          RUN: begin
            if (fire) begin
              spike_q <= 1'b1;
              v       <= '0;
              if (refr != '0) begin
                state   <= REFRAC;
                ref_cnt <= refr;
              end
            end else begin
              v <= v_next;
            end
          end
          REFRAC: begin
            v       <= '0;
            ref_cnt <= ref_cnt - 1'b1;
            if (ref_cnt <= REF_W'(1)) state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign io.spike_out    = spike_q;
  assign io.v_mem_out    = v;
  assign io.params_ready = ready_q;
  assign io.cfg_err      = err_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] spike_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_cnt <= '0;
    end else if (commit) begin
      spike_cnt <= '0;
    end else if (spike_ev && spike_cnt != 8'hff) begin
      spike_cnt <= spike_cnt + 1'b1;
    end
  end

  assign io.spike_count = spike_cnt;
`else
  logic unused_ev;
  assign unused_ev = spike_ev;
  assign io.spike_count = 8'd0;
`endif
endmodule
